option_stream_decoder: RTL and testbench
========================================

OPTION_STREAM_DECODER -- requirements
Module: option_stream_decoder

Interface
REQ-001 Parameter: PAYLOAD_W, default 16, payload width of the Option<uint<PAYLOAD_W>> encoding.
REQ-002 Parameter: DEPTH, default 4, buffer entries; power of two, minimum 2.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 opt_i  input  PAYLOAD_W+1  option-encoded word: bit[PAYLOAD_W] is the tag, 0 = Some, 1 = None; bits[PAYLOAD_W-1:0] are the payload.
REQ-006 opt_valid_i  input  1  opt_i is presented this cycle; no input backpressure.
REQ-007 ready_i  input  1  consumer pops the head entry this cycle.
REQ-008 output__  output  PAYLOAD_W+1  head of buffer, re-encoded as an option word.
REQ-009 level_o  output  clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-010 none_count_o  output  8  count of accepted None words, saturating.
REQ-011 overflow_o  output  1  sticky flag: a Some payload was dropped.

Function
REQ-012 A Some word with opt_valid_i=1 SHALL push its payload when level < DEPTH.
REQ-013 A Some word arriving when full with no pop SHALL be dropped, and overflow_o SHALL be set to 1 from the next cycle until reset.
REQ-014 A None word with opt_valid_i=1 SHALL increment none_count_o, saturating at 255, and SHALL NOT push.
REQ-015 opt_i SHALL be ignored entirely when opt_valid_i=0.
REQ-016 output__ SHALL equal {0, head payload} when level > 0 and {1, all-zero payload} when level = 0; it SHALL be driven combinationally from registered state only, with no opt_i-to-output__ path.
REQ-017 Push-to-visible latency SHALL be 1 cycle; a word pushed into an empty buffer appears on output__ the following cycle (no fall-through).
REQ-018 A pop SHALL occur when ready_i=1 and level > 0; ready_i with level = 0 SHALL have no effect.
REQ-019 Simultaneous push and pop when full SHALL accept the push, with level unchanged and no overflow.
REQ-020 Simultaneous push and pop at a non-zero, non-full level SHALL leave level unchanged; when empty, the push is accepted and no pop occurs.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across wrap.
REQ-022 level_o SHALL update on the clock edge following each push/pop event.

Reset
REQ-023 While rst_i=1 at a rising edge: level 0, both pointers 0, none_count_o 0, overflow_o 0.
REQ-024 After reset, output__ SHALL read {1, 0}.
REQ-025 Reset SHALL dominate any push, pop, or None count presented in the same cycle.
REQ-026 Storage contents are not reset and SHALL NOT be observable while level = 0.
REQ-027 Reset asserted mid-stream SHALL discard all buffered entries.

Structure
REQ-028 Shared package option_pkg SHALL hold:
  - OPT_TAG_SOME = 0 and OPT_TAG_NONE = 1
  - the encoded-width helper (payload width + 1)
REQ-029 Storage and pointers SHALL live in one sub-module, opt_ring_buf (push/pop/level/head).
REQ-030 Tag decode, None counter and overflow flag SHALL live in option_stream_decoder.

Verification
REQ-031 Reset, then opt_i=0x0007B with valid=1 for one cycle -> next cycle output__=0x0007B, level_o=1; ready_i=1 for one cycle -> output__=0x10000, level_o=0.
REQ-032 Push Some 1,2,3,4, then Some 5 with ready_i=0 -> level_o=4, overflow_o=1; pops return 1,2,3,4 in order.
REQ-033 Full buffer, Some 9 with ready_i=1 in the same cycle -> level_o stays 4, overflow_o stays 0; tail entry is 9.
REQ-034 260 consecutive None words (opt_i=0x10000, valid=1) -> none_count_o=255, level_o=0, output__=0x10000.
REQ-035 Push/pop interleaved for 10 words over wrap -> output order matches input; then rst_i=1 with Some presented in the same cycle -> level_o=0, overflow_o=0, output__=0x10000.

Source files
------------

// File: rtl/option_pkg.sv
// Shared definitions for the option-word stream decoder.
// Holds the tag encoding of an Option<uint<N>> word and the encoded-width
// helper (payload width plus one tag bit).
package option_pkg;

  localparam logic OPT_TAG_SOME = 1'b0;
  localparam logic OPT_TAG_NONE = 1'b1;

  // Width of an option-encoded word carrying a pw-bit payload.
  function automatic int enc_w(input int pw);
    return pw + 1;
  endfunction

endpackage

// File: rtl/opt_ring_buf.sv
// Ring buffer holding decoded Some payloads.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (pointers/level only)
//   push, din    : write din at the tail (caller only pushes when legal)
//   pop          : drop the head entry (caller only pops when level > 0)
//   head         : payload at the read pointer (undefined while level = 0)
//   level        : entry count, 0..DEPTH
module opt_ring_buf #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Storage is deliberately not reset; level gates visibility instead.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/option_stream_decoder.sv
// Decodes a stream of option-encoded words: Some payloads are buffered,
// None words are counted (saturating), dropped Some payloads raise a sticky
// overflow flag. The buffer head is re-encoded as an option word.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   opt_i         : {tag, payload}, tag 0 = Some, 1 = None
//   opt_valid_i   : opt_i present this cycle (no backpressure)
//   ready_i       : consumer pops the head this cycle
//   output__      : head as option word; None when empty
//   level_o       : entry count
//   none_count_o  : accepted None words, saturating at 255
//   overflow_o    : sticky, a Some payload was dropped
module option_stream_decoder
  import option_pkg::*;
#(
  parameter  int PAYLOAD_W = 16,
  parameter  int DEPTH     = 4,
  localparam int EW        = enc_w(PAYLOAD_W),
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [EW-1:0] opt_i,
  input  logic          opt_valid_i,
  input  logic          ready_i,
  output logic [EW-1:0] output__,
  output logic [LW-1:0] level_o,
  output logic [7:0]    none_count_o,
  output logic          overflow_o
);

  logic                 is_some;
  logic                 is_none;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic [PAYLOAD_W-1:0] head;

  assign is_some = opt_valid_i && (opt_i[PAYLOAD_W] == OPT_TAG_SOME);
  assign is_none = opt_valid_i && (opt_i[PAYLOAD_W] == OPT_TAG_NONE);
  assign full    = (level_o == LW'(DEPTH));
  assign pop     = ready_i && (level_o != '0);
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push    = is_some && (!full || pop);

  opt_ring_buf #(.W(PAYLOAD_W), .DEPTH(DEPTH)) u_buf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (opt_i[PAYLOAD_W-1:0]),
    .head  (head),
    .level (level_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      none_count_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (is_none && none_count_o != 8'hFF) none_count_o <= none_count_o + 8'd1;
      if (is_some && !push)                 overflow_o   <= 1'b1;
    end
  end

  // Registered state only: an empty buffer never exposes stale storage.
  assign output__ = (level_o != '0) ? {OPT_TAG_SOME, head}
                                    : {OPT_TAG_NONE, {PAYLOAD_W{1'b0}}};

endmodule

// File: tb/tb_option_stream_decoder.sv
module tb_option_stream_decoder;

  localparam int PW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [PW:0]   opt_i = '0;
  logic          opt_valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [PW:0]   output__;
  logic [LW-1:0] level_o;
  logic [7:0]    none_count_o;
  logic          overflow_o;

  option_stream_decoder #(.PAYLOAD_W(PW), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .opt_i        (opt_i),
    .opt_valid_i  (opt_valid_i),
    .ready_i      (ready_i),
    .output__     (output__),
    .level_o      (level_o),
    .none_count_o (none_count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of payloads plus counters.
  logic [PW-1:0] q[$];
  int            m_none = 0;
  bit            m_ovf  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW:0] m_out();
    return (q.size() > 0) ? {1'b0, q[0]} : {1'b1, {PW{1'b0}}};
  endfunction

  // Drive one cycle, advance the model at the edge, check at the falling edge.
  task automatic tick(input logic r, input logic v, input logic [PW:0] o, input logic rd);
    bit did_pop;
    rst_i = r; opt_valid_i = v; opt_i = o; ready_i = rd;
    @(posedge clk_i);
    if (r) begin
      q.delete(); m_none = 0; m_ovf = 0;
    end else begin
      did_pop = rd && (q.size() > 0);
      if (did_pop) void'(q.pop_front());
      if (v && !o[PW]) begin
        if (q.size() < DEPTH) q.push_back(o[PW-1:0]);
        else m_ovf = 1;
      end
      if (v && o[PW] && m_none < 255) m_none++;
    end
    @(negedge clk_i);
    chk("output", 32'(output__), 32'(m_out()));
    chk("level", 32'(level_o), 32'(q.size()));
    chk("none_count", 32'(none_count_o), 32'(m_none));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
  endtask

  function automatic logic [PW:0] some(input int p);
    return {1'b0, PW'(p)};
  endfunction

  localparam logic [PW:0] NONE_W = {1'b1, {PW{1'b0}}};

  initial begin
    logic [PW:0] w;
    int          k;
    tick(1, 0, '0, 0);
    tick(1, 1, some(5), 1);
    chk("rst_output", 32'(output__), 32'h10000);
    chk("rst_level", 32'(level_o), 0);

    // Single push / pop.
    tick(0, 1, 17'h0007B, 0);
    chk("push1_out", 32'(output__), 32'h0007B);
    chk("push1_level", 32'(level_o), 1);
    tick(0, 0, '0, 1);
    chk("pop1_out", 32'(output__), 32'h10000);
    chk("pop1_level", 32'(level_o), 0);
    tick(0, 0, '0, 1); // pop on empty has no effect

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) tick(0, 1, some(i), 0);
    tick(0, 1, some(5), 0);
    chk("full_level", 32'(level_o), 4);
    chk("full_ovf", 32'(overflow_o), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(output__), 32'(i));
      tick(0, 0, '0, 1);
    end

    // Push and pop together while full.
    tick(1, 0, '0, 0);
    for (int i = 1; i <= 4; i++) tick(0, 1, some(i), 0);
    tick(0, 1, some(9), 1);
    chk("pp_level", 32'(level_o), 4);
    chk("pp_ovf", 32'(overflow_o), 0);
    for (int i = 0; i < 4; i++) begin
      w = output__;
      tick(0, 0, '0, 1);
    end
    chk("pp_tail", 32'(w), 32'h00009);

    // None saturation.
    for (int i = 0; i < 260; i++) tick(0, 1, NONE_W, 0);
    chk("none_sat", 32'(none_count_o), 255);
    chk("none_level", 32'(level_o), 0);
    chk("none_out", 32'(output__), 32'h10000);

    // Interleaved 10 words across the wrap, then reset with Some presented.
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, some(16'h100 + i), 0);
      if (i % 2 == 1) begin
        chk("wrap_order", 32'(output__), 32'(16'h100 + k)); k++;
        tick(0, 0, '0, 1);
      end
    end
    tick(0, 1, some(16'hAAA), 0);
    tick(1, 1, some(16'h55), 1);
    chk("rst_mid_level", 32'(level_o), 0);
    chk("rst_mid_ovf", 32'(overflow_o), 0);
    chk("rst_mid_out", 32'(output__), 32'h10000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      w = {($urandom_range(0, 3) == 0), PW'($urandom)};
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), w,
           ($urandom_range(0, 9) < 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
